karatsuba_sgf_mult: RTL and testbench

- Unsigned SW×SW significand multiplier for the FPU multiply path.
- Uses one level of Karatsuba decomposition: three half-width sub-products, two subtractions and one final addition.
- The full 2·SW-bit product is captured in a load-enabled output register.
- Sits between operand alignment and the normalisation/rounding stage.

---
 rtl/karatsuba_sgf_mult_pkg.sv | 16 +
 rtl/sgf_sub_mult.sv | 14 +
 rtl/karatsuba_sgf_mult.sv | 84 ++++++++
 tb/tb_karatsuba_sgf_mult.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/karatsuba_sgf_mult_pkg.sv
// Width helpers for the Karatsuba significand multiplier.
// The operand is split into a high part of floor(SW/2) bits and a low part
// that takes the remaining bits. For odd SW the low part is one bit wider.
package karatsuba_sgf_mult_pkg;

  // Width of the high operand half.
  function automatic int sgf_hi_width(input int sw);
    return sw / 32'sd2;
  endfunction

  // Width of the low operand half.
  function automatic int sgf_lo_width(input int sw);
    return sw - (sw / 32'sd2);
  endfunction

endpackage

// File: rtl/sgf_sub_mult.sv
// Combinational unsigned W x W -> 2W multiplier used for the Karatsuba
// sub-products. It has no clock and no state.
module sgf_sub_mult #(
  parameter int W = 2
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  // Both factors are widened first so the full 2W-bit product is kept.
  assign p = (2*W)'(a) * (2*W)'(b);

endmodule

// File: rtl/karatsuba_sgf_mult.sv
// Unsigned SW x SW significand multiplier, one level of Karatsuba.
// The operands are split into high/low halves; three half-width products
// (high, low, and the product of the half-sums) are combined into the full
// product, which is captured in a load-enabled output register.
module karatsuba_sgf_mult
  import karatsuba_sgf_mult_pkg::*;
#(
  parameter int SW = 54
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_b_i,
  input  logic [SW-1:0]   Data_A_i,
  input  logic [SW-1:0]   Data_B_i,
  output logic [2*SW-1:0] sgf_result_o
);

  localparam int H  = sgf_hi_width(SW);
  localparam int L  = sgf_lo_width(SW);
  localparam int PW = 2 * SW;
  localparam int MW = 2 * L + 2;

  logic [H-1:0]    a_hi_s;
  logic [H-1:0]    b_hi_s;
  logic [L-1:0]    a_lo_s;
  logic [L-1:0]    b_lo_s;
  logic [L:0]      sum_a_s;
  logic [L:0]      sum_b_s;
  logic [2*H-1:0]  p_left_s;
  logic [2*L-1:0]  p_right_s;
  logic [MW-1:0]   p_mid_s;
  logic [MW-1:0]   cross_s;
  logic [PW-1:0]   prod_s;
  logic [PW-1:0]   result_r;

  assign a_hi_s = Data_A_i[SW-1:L];
  assign a_lo_s = Data_A_i[L-1:0];
  assign b_hi_s = Data_B_i[SW-1:L];
  assign b_lo_s = Data_B_i[L-1:0];

  // Half-sums keep their carry bit; the high half is zero-extended first.
  assign sum_a_s = (L+1)'(a_hi_s) + (L+1)'(a_lo_s);
  assign sum_b_s = (L+1)'(b_hi_s) + (L+1)'(b_lo_s);

  sgf_sub_mult #(.W(H)) u_left (
    .a (a_hi_s),
    .b (b_hi_s),
    .p (p_left_s)
  );

  sgf_sub_mult #(.W(L)) u_right (
    .a (a_lo_s),
    .b (b_lo_s),
    .p (p_right_s)
  );

  sgf_sub_mult #(.W(L+1)) u_mid (
    .a (sum_a_s),
    .b (sum_b_s),
    .p (p_mid_s)
  );

  // Cross term Ah*Bl + Al*Bh; the true value is non-negative, so the
  // subtraction never borrows out of MW bits.
  assign cross_s = p_mid_s - MW'(p_left_s) - MW'(p_right_s);

  // {PL, PR} + (M << L). The exact product fits in PW bits, so any carry
  // beyond PW is provably zero and wrapping arithmetic yields the exact result.
  assign prod_s = {p_left_s, p_right_s} + (PW'(cross_s) << L);

  // Output register: asynchronous clear, capture the product on load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_r <= {PW{1'b0}};
    end else if (load_b_i) begin
      result_r <= prod_s;
    end else begin
      result_r <= result_r;
    end
  end

  assign sgf_result_o = result_r;

endmodule

// File: tb/tb_karatsuba_sgf_mult.sv
// Self-checking bench for karatsuba_sgf_mult at SW=54 and SW=53.
// A plain-arithmetic reference product is compared against both DUTs on
// every falling edge; directed cases also check hand-computed literals.
module tb_karatsuba_sgf_mult;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [53:0]  a54 = 54'd0;
  logic [53:0]  b54 = 54'd0;
  logic [52:0]  a53 = 53'd0;
  logic [52:0]  b53 = 53'd0;
  logic [107:0] res54;
  logic [105:0] res53;

  logic [107:0] exp54 = 108'd0;
  logic [105:0] exp53 = 106'd0;

  int checks = 0;
  int errors = 0;

  karatsuba_sgf_mult #(.SW(54)) dut54 (
    .clk          (clk),
    .rst          (rst),
    .load_b_i     (load),
    .Data_A_i     (a54),
    .Data_B_i     (b54),
    .sgf_result_o (res54)
  );

  karatsuba_sgf_mult #(.SW(53)) dut53 (
    .clk          (clk),
    .rst          (rst),
    .load_b_i     (load),
    .Data_A_i     (a53),
    .Data_B_i     (b53),
    .sgf_result_o (res53)
  );

  always #5 clk = ~clk;

  // Reference: the register holds the plain product of the last loaded operands.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp54 = 108'd0;
      exp53 = 106'd0;
    end else if (load) begin
      exp54 = {54'd0, a54} * {54'd0, b54};
      exp53 = {53'd0, a53} * {53'd0, b53};
    end
  end

  task automatic chk(input string nm, input logic [107:0] act, input logic [107:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Continuous comparison against the reference on every falling edge.
  always @(negedge clk) begin
    chk("model54", res54, exp54);
    chk("model53", {2'd0, res53}, {2'd0, exp53});
  end

  // Drive one cycle of inputs, then wait until just after the next rising edge.
  task automatic cyc(input logic [53:0] a, input logic [53:0] b,
                     input logic [52:0] c, input logic [52:0] d, input logic ld);
    a54 = a; b54 = b; a53 = c; b53 = d; load = ld;
    @(posedge clk);
    #3;
  endtask

  function automatic logic [53:0] rnd54();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 9))
      0:       return {54{1'b1}};
      1:       return 54'd0;
      2:       return {27'h7FFFFFF, 27'd0} | {27'd0, r[26:0]};
      default: return r[53:0];
    endcase
  endfunction

  function automatic logic [52:0] rnd53();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 9))
      0:       return {53{1'b1}};
      1:       return 53'd0;
      2:       return {26'h3FFFFFF, 27'd0} | {26'd0, r[26:0]};
      default: return r[52:0];
    endcase
  endfunction

  initial begin
    logic [107:0] p106;
    logic [53:0]  all54;
    logic [52:0]  all53;
    all54 = {54{1'b1}};
    all53 = {53{1'b1}};
    p106 = 108'd0;
    p106[106] = 1'b1;

    // Reset held with nonzero operands and load asserted.
    a54 = 54'h123456789; b54 = 54'h3ABCDEF; a53 = 53'h55; b53 = 53'h77; load = 1'b1;
    #1;
    chk("reset_async54", res54, 108'd0);
    chk("reset_async53", {2'd0, res53}, 108'd0);
    repeat (3) @(posedge clk);
    #3;
    chk("reset_edges54", res54, 108'd0);
    rst = 1'b1;

    // Directed SW=54 and SW=53 cases.
    cyc(all54, all54, all53, all53, 1'b1);
    chk("max54", res54, 108'hFFF_FFFF_FFFF_FF80_0000_0000_0001);
    chk("max53", {2'd0, res53}, {2'd0, 106'h3FF_FFFF_FFFF_FFC0_0000_0000_0001});
    cyc(54'd0, all54, 53'h10000000000000, 53'd3, 1'b1);
    chk("zero54", res54, 108'd0);
    chk("pow53x3", {2'd0, res53}, 108'h30000000000000);
    cyc(54'd1, 54'h2AAAAAAAAAAAAA, 53'd1, 53'd0, 1'b1);
    chk("ident54", res54, 108'h2AAAAAAAAAAAAA);
    cyc(54'h20000000000000, 54'h20000000000000, 53'd0, 53'd0, 1'b1);
    chk("pow54", res54, p106);
    cyc(54'h3FFFFFF8000001, 54'h3FFFFFF8000001, 53'd5, 53'd9, 1'b1);
    chk("carry54", res54, {54'd0, 54'h3FFFFFF8000001} * {54'd0, 54'h3FFFFFF8000001});

    // Hold: load 6*7, then change operands with load low.
    cyc(54'd6, 54'd7, 53'd6, 53'd7, 1'b1);
    chk("hold_load", res54, 108'd42);
    for (int i = 0; i < 5; i++) begin
      cyc(rnd54(), rnd54(), rnd53(), rnd53(), 1'b0);
      chk("hold54", res54, 108'd42);
      chk("hold53", {2'd0, res53}, 108'd42);
    end
    cyc(54'd9, 54'd11, 53'd13, 53'd3, 1'b1);
    chk("reload54", res54, 108'd99);
    chk("reload53", {2'd0, res53}, 108'd39);

    // Reset mid-operation clears immediately; the first load after it is exact.
    rst = 1'b0;
    #1;
    chk("midreset54", res54, 108'd0);
    chk("midreset53", {2'd0, res53}, 108'd0);
    cyc(54'd100, 54'd3, 53'd100, 53'd4, 1'b1);
    chk("reset_wins", res54, 108'd0);
    rst = 1'b1;
    cyc(54'd100, 54'd3, 53'd100, 53'd4, 1'b1);
    chk("post_reset54", res54, 108'd300);
    chk("post_reset53", {2'd0, res53}, 108'd400);

    // Random regression, load mostly asserted.
    for (int i = 0; i < 10000; i++) begin
      cyc(rnd54(), rnd54(), rnd53(), rnd53(), ($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
